// File: rtl/shift_unit.sv
// ---------------------------------------------------------------------------
// shift_unit
//   Multi-cycle shift/rotate unit for the execute stage. One operation is
//   accepted per start pulse while idle; the operand is shifted StepBits
//   positions per cycle until the shift amount is consumed, then done is
//   strobed for one cycle. busy lets the hazard unit stall the pipeline.
//
//   Optional feature macro: SHIFT_ROTATE_EN
//     defined   : op=3 performs rotate-left (ROL)
//     undefined : rotate path is not built; op=3 behaves exactly as LSL
//
// Parameters
//   DataWidth  operand/result width (power of two, >= 4)
//   StepBits   bit positions shifted per SHIFT cycle (power of two, 1..DataWidth)
//   ShamtBits  shift-amount width
//
// Ports
//   CLK     in   clock, rising edge
//   RST     in   asynchronous active-low reset
//   start   in   request, sampled only when idle
//   op      in   0=LSL 1=LSR 2=ASR 3=ROL
//   a       in   operand, captured with start
//   shamt   in   shift amount, captured with start
//   busy    out  high while an operation is in flight (SHIFT and DONE)
//   done    out  one-cycle strobe; result/carry valid
//   result  out  working register (final value from done, held until next start)
//   carry   out  last bit shifted/rotated out; 0 when shamt=0
// ---------------------------------------------------------------------------
module shift_unit #(
    parameter int unsigned DataWidth = 16,
    parameter int unsigned StepBits  = 1,
    parameter int unsigned ShamtBits = $clog2(DataWidth)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [DataWidth-1:0] a,
    input  logic [ShamtBits-1:0] shamt,
    output logic                 busy,
    output logic                 done,
    output logic [DataWidth-1:0] result,
    output logic                 carry
);

    // One extra bit so StepBits == DataWidth is representable in compares.
    localparam int unsigned CntW = ShamtBits + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_LSL = 2'd0,
        OP_LSR = 2'd1,
        OP_ASR = 2'd2,
        OP_ROL = 2'd3
    } op_e;

    state_e                 state_q,     state_d;
    op_e                    op_q,        op_d;
    logic                   sign_q,      sign_d;
    logic [ShamtBits-1:0]   remaining_q, remaining_d;
    logic [DataWidth-1:0]   work_q,      work_d;
    logic                   carry_q,     carry_d;
    logic                   busy_q,      busy_d;
    logic                   done_q,      done_d;

    op_e                    op_in;
    logic [DataWidth-1:0]   step_work;
    logic                   step_carry;
    logic [ShamtBits-1:0]   step_remaining;

    // Map the requested opcode onto the operations this build supports.
    always_comb begin
`ifdef SHIFT_ROTATE_EN
        op_in = op_e'(op);
`else
        op_in = (op == 2'd3) ? OP_LSL : op_e'(op);
`endif
    end

    // One SHIFT cycle: apply min(StepBits, remaining) single-bit moves.
    // Carry ends up holding the bit moved out by the last active move.
    always_comb begin
        step_work  = work_q;
        step_carry = carry_q;
        for (int unsigned i = 0; i < StepBits; i++) begin
            if (CntW'(i) < CntW'(remaining_q)) begin
                case (op_q)
                    OP_LSR: begin
                        step_carry = step_work[0];
                        step_work  = {1'b0, step_work[DataWidth-1:1]};
                    end
                    OP_ASR: begin
                        step_carry = step_work[0];
                        step_work  = {sign_q, step_work[DataWidth-1:1]};
                    end
`ifdef SHIFT_ROTATE_EN
                    OP_ROL: begin
                        step_carry = step_work[DataWidth-1];
                        step_work  = {step_work[DataWidth-2:0], step_work[DataWidth-1]};
                    end
`endif
                    default: begin
                        step_carry = step_work[DataWidth-1];
                        step_work  = {step_work[DataWidth-2:0], 1'b0};
                    end
                endcase
            end
        end
    end

    // Remaining count after this cycle's step, saturating at zero.
    always_comb begin
        if (CntW'(remaining_q) <= CntW'(StepBits)) begin
            step_remaining = '0;
        end else begin
            step_remaining = remaining_q - ShamtBits'(StepBits);
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        sign_d      = sign_q;
        remaining_d = remaining_q;
        work_d      = work_q;
        carry_d     = carry_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d        = op_in;
                    sign_d      = a[DataWidth-1];
                    remaining_d = shamt;
                    work_d      = a;
                    carry_d     = 1'b0;
                    busy_d      = 1'b1;
                    if (shamt != '0) begin
                        state_d = SHIFT;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            SHIFT: begin
                work_d      = step_work;
                carry_d     = step_carry;
                remaining_d = step_remaining;
                if (step_remaining == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            op_q        <= OP_LSL;
            sign_q      <= 1'b0;
            remaining_q <= '0;
            work_q      <= '0;
            carry_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            sign_q      <= sign_d;
            remaining_q <= remaining_d;
            work_q      <= work_d;
            carry_q     <= carry_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = work_q;
    assign carry  = carry_q;

endmodule

// File: tb/tb_shift_unit.sv
// ---------------------------------------------------------------------------
// tb_shift_unit
//   Scoreboard bench for shift_unit. Two instances share the stimulus: one
//   with StepBits=1 and one with StepBits=2, so result/carry are common and
//   only the expected latency differs. The stimulus process pushes expected
//   responses; a monitor pops and compares on every done strobe.
// ---------------------------------------------------------------------------
module tb_shift_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [15:0] a = 16'h0;
    logic [3:0]  shamt = 4'd0;

    logic        busy1, done1, carry1;
    logic [15:0] result1;
    logic        busy2, done2, carry2;
    logic [15:0] result2;

    int cyc    = 0;
    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [15:0] res;
        logic        c;
        int          lat;
        int          issue;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    shift_unit #(.DataWidth(16), .StepBits(1)) dut1 (
        .CLK(CLK), .RST(RST), .start(start), .op(op), .a(a), .shamt(shamt),
        .busy(busy1), .done(done1), .result(result1), .carry(carry1)
    );

    shift_unit #(.DataWidth(16), .StepBits(2)) dut2 (
        .CLK(CLK), .RST(RST), .start(start), .op(op), .a(a), .shamt(shamt),
        .busy(busy2), .done(done2), .result(result2), .carry(carry2)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        exp_t e;
        if (done1) begin
            if (q1.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL d1_unexpected_done: result 0x%0h with no pending op (cycle %0d)", result1, cyc);
            end else begin
                e = q1.pop_front();
                check("d1_result",  32'(result1), 32'(e.res));
                check("d1_carry",   32'(carry1),  32'(e.c));
                check("d1_latency", 32'(cyc - e.issue), 32'(e.lat));
            end
        end
        if (done2) begin
            if (q2.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL d2_unexpected_done: result 0x%0h with no pending op (cycle %0d)", result2, cyc);
            end else begin
                e = q2.pop_front();
                check("d2_result",  32'(result2), 32'(e.res));
                check("d2_carry",   32'(carry2),  32'(e.c));
                check("d2_latency", 32'(cyc - e.issue), 32'(e.lat));
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_busy1"},   32'(busy1),   32'h0);
        check({tag, "_done1"},   32'(done1),   32'h0);
        check({tag, "_result1"}, 32'(result1), 32'h0);
        check({tag, "_carry1"},  32'(carry1),  32'h0);
        check({tag, "_busy2"},   32'(busy2),   32'h0);
        check({tag, "_done2"},   32'(done2),   32'h0);
        check({tag, "_result2"}, 32'(result2), 32'h0);
        check({tag, "_carry2"},  32'(carry2),  32'h0);
    endtask

    // Wait (at negedges) until both units are idle, bounded.
    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (!busy1 && !busy2) return;
            @(negedge CLK);
        end
        checks++;
        fails++;
        $display("FAIL wait_idle: busy1=%0b busy2=%0b after 200 cycles", busy1, busy2);
    endtask

    // Issue one request; expected latency is ceil(shamt/StepBits)+1.
    task automatic issue(input logic [1:0] o, input logic [15:0] av, input logic [3:0] sh,
                         input logic [15:0] er, input logic ec, input bit expect_done);
        exp_t e;
        wait_idle();
        start = 1'b1;
        op    = o;
        a     = av;
        shamt = sh;
        if (expect_done) begin
            e.res   = er;
            e.c     = ec;
            e.issue = cyc;
            e.lat   = int'(sh) + 1;
            q1.push_back(e);
            e.lat   = (int'(sh) + 1) / 2 + 1;
            q2.push_back(e);
        end
        @(negedge CLK);
        start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge CLK);
        check_zero("reset");
        RST = 1'b1;
        @(negedge CLK);

        issue(2'd0, 16'hFFFA, 4'd1, 16'hFFF4, 1'b1, 1'b1);
        check("busy_after_start", 32'(busy1), 32'h1);
        issue(2'd0, 16'hFFF4, 4'd3, 16'hFFA0, 1'b1, 1'b1);
        issue(2'd1, 16'h8000, 4'd15, 16'h0001, 1'b0, 1'b1);
        issue(2'd2, 16'h8000, 4'd15, 16'hFFFF, 1'b0, 1'b1);
        issue(2'd0, 16'h8000, 4'd0, 16'h8000, 1'b0, 1'b1);
        issue(2'd2, 16'h8004, 4'd3, 16'hF000, 1'b1, 1'b1);
`ifdef SHIFT_ROTATE_EN
        issue(2'd3, 16'h8001, 4'd1, 16'h0003, 1'b1, 1'b1);
`else
        issue(2'd3, 16'h8001, 4'd1, 16'h0002, 1'b1, 1'b1);
`endif

        // A start pulse while busy must be dropped.
        issue(2'd0, 16'h0001, 4'd8, 16'h0100, 1'b0, 1'b1);
        @(negedge CLK);
        start = 1'b1;
        op    = 2'd0;
        a     = 16'hFFFF;
        shamt = 4'd4;
        @(negedge CLK);
        start = 1'b0;
        wait_idle();
        repeat (4) @(negedge CLK);
        check("busy_protect_q1_empty", 32'(q1.size()), 32'h0);
        check("busy_protect_q2_empty", 32'(q2.size()), 32'h0);
        check("busy_protect_result1", 32'(result1), 32'h0100);

        // Reset mid-operation: aborted op never reports done.
        issue(2'd0, 16'h0003, 4'd10, 16'h0, 1'b0, 1'b0);
        @(negedge CLK);
        check("midop_busy1", 32'(busy1), 32'h1);
        RST = 1'b0;
        #1;
        check_zero("midop_reset");
        @(negedge CLK);
        RST = 1'b1;
        repeat (15) @(negedge CLK);

        issue(2'd1, 16'h00F8, 4'd4, 16'h000F, 1'b1, 1'b1);
        wait_idle();
        repeat (4) @(negedge CLK);
        check("final_q1_empty", 32'(q1.size()), 32'h0);
        check("final_q2_empty", 32'(q2.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/shift_unit.md
# shift_unit

Parametrised multi-cycle shift/rotate unit for the pipelined processor's execute stage. It generalises the single-cycle LSI path to a configurable data width and a configurable number of bit positions per cycle. It supports logical-left, logical-right and arithmetic-right shifts, plus rotate-left when that feature is compiled in. It accepts one operation per start pulse and returns the result with a one-cycle done strobe, so the hazard unit can stall the pipeline on busy.

## Interface
- DataWidth, 16, operand/result width in bits (power of two, ≥4)
- StepBits, 1, bit positions shifted per SHIFT cycle (power of two, 1..DataWidth)
- ShamtBits, $clog2(DataWidth), shift-amount width
- CLK  input  1  clock; all state updates on rising edge
- RST  input  1  reset, asynchronous, active-low; one clock domain only
- start  input  1  request; sampled only in IDLE
- op  input  2  0=LSL, 1=LSR, 2=ASR, 3=ROL (see Configuration)
- a  input  DataWidth  operand, captured with start
- shamt  input  ShamtBits  shift amount, captured with start
- busy  output  1  high in SHIFT and DONE states
- done  output  1  one-cycle strobe; result/carry valid
- result  output  DataWidth  shifted value; held until next accepted start
- carry  output  1  last bit shifted or rotated out; 0 when shamt=0

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: when start=1, capture a, op and shamt into internal regs and load remaining=shamt. Go to SHIFT if shamt≠0; otherwise go to DONE.
- SHIFT: each cycle, shift by k=min(StepBits, remaining) and set remaining-=k. The carry reg takes the last bit shifted out during that step. When remaining reaches 0, go to DONE.
- Shift rules:
  - LSL fills with 0; carry takes the MSB side bit.
  - LSR fills with 0; carry takes the LSB side bit.
  - ASR fills with the captured sign bit; carry takes the LSB side bit.
  - ROL moves bit DataWidth-1 into bit 0; carry is the last bit moved.
- DONE: done=1 for exactly one cycle, then return to IDLE.
- result/carry:
  - Updated only by the shifter.
  - Captured values are visible from the DONE cycle.
  - Held until the next accepted start.
  - The internal working reg drives result, so intermediate values are visible while busy; consumers use only done.
- start while busy=1 is ignored, with no queueing.
- start in the same cycle that DONE returns to IDLE is not accepted. A new op needs start asserted with busy=0.
- shamt maximum is DataWidth-1. No modulo is needed; the width prevents larger values.

## Timing
- Reset (RST=0, async): state=IDLE, busy=0, done=0, result=0, carry=0, remaining=0.
- Reset mid-operation aborts immediately with the same values. After RST=1, no done is issued for the aborted op.
- Start sampled at edge E0. busy=1 from after E0.
- done=1 during cycle ceil(shamt/StepBits)+1 after E0. With shamt=0, latency is 1 cycle.
- busy falls together with done at the edge that leaves DONE.
- Back-to-back throughput: one op per ceil(shamt/StepBits)+2 cycles.
- Outputs are registered only; there is no combinational path from the inputs.

## Configuration
- SHIFT_ROTATE_EN defined:
  - op=3 performs ROL as specified.
- SHIFT_ROTATE_EN undefined:
  - The rotate path is not synthesised.
  - op=3 executes as LSL, with identical result, carry and latency.

## Test plan
- Reset, then op=LSL, a=0xFFFA, shamt=1 -> done one cycle later than shamt=0 latency+1 (2 cycles after start), result=0xFFF4, carry=1.
- Chained: a=0xFFF4, LSL, shamt=3, StepBits=1 -> done 4 cycles after start, result=0xFFA0, carry=1. With StepBits=2 -> done 3 cycles after start, same values.
- Shift modes on 0x8000:
  - LSR shamt=15 -> result=0x0001, carry=0.
  - ASR shamt=15 -> result=0xFFFF, carry=0.
  - shamt=0 -> result=0x8000, carry=0, done after 1 cycle.
- op=ROL, a=0x8001, shamt=1:
  - With SHIFT_ROTATE_EN -> result=0x0003, carry=1.
  - Without SHIFT_ROTATE_EN -> result=0x0002, carry=1.
- Busy protection: start LSL a=0x0001 shamt=8, then pulse start with a=0xFFFF mid-operation -> second request ignored, result=0x0100, exactly one done.
- Reset mid-operation: drive RST=0 two cycles into a shamt=10 op -> busy/done/result/carry=0 immediately, no done after release, and the next op completes normally.
